// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between the fetch (imem) and load/store (dmem) requesters.
// Latency: request in cycle N -> mem mask pulse in N+1 -> earliest imem/dmem resp in N+2.
// Backpressure: one pending slot per port; a pulse into a full or in-flight slot is dropped.
//
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   imem_*                     fetch request (addr, rmask pulse) and response (rdata, resp pulse)
//   dmem_*                     load/store request (addr, rmask/wmask pulse, wdata) and response
//   mem_*                      registered request to the memory, combinational response from it
//   busy_o                     high whenever a transaction is in flight
//
// Build option: define ARB_RR_EN for round-robin arbitration on ties; without it dmem has
// fixed priority over imem.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MASK_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] imem_addr_i,
  input  logic [MASK_W-1:0] imem_rmask_i,
  output logic [DATA_W-1:0] imem_rdata_o,
  output logic              imem_resp_o,
  input  logic [ADDR_W-1:0] dmem_addr_i,
  input  logic [MASK_W-1:0] dmem_rmask_i,
  input  logic [MASK_W-1:0] dmem_wmask_i,
  input  logic [DATA_W-1:0] dmem_wdata_i,
  output logic [DATA_W-1:0] dmem_rdata_o,
  output logic              dmem_resp_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [MASK_W-1:0] mem_rmask_o,
  output logic [MASK_W-1:0] mem_wmask_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_resp_i,
  output logic              busy_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT_I = 2'd1;
  localparam logic [1:0] ST_WAIT_D = 2'd2;

  logic [1:0]        state_q;

  // Per-port slots; a slot stays valid while its request is in flight and
  // is cleared only when the memory response for it completes.
  logic              i_vld_q;
  logic [ADDR_W-1:0] i_addr_q;
  logic [MASK_W-1:0] i_rmask_q;
  logic              d_vld_q;
  logic [ADDR_W-1:0] d_addr_q;
  logic [MASK_W-1:0] d_rmask_q;
  logic [MASK_W-1:0] d_wmask_q;
  logic [DATA_W-1:0] d_wdata_q;

  logic              i_req;
  logic              d_req;
  logic              i_cand;
  logic              d_cand;
  logic [ADDR_W-1:0] i_c_addr;
  logic [MASK_W-1:0] i_c_rmask;
  logic [ADDR_W-1:0] d_c_addr;
  logic [MASK_W-1:0] d_c_rmask;
  logic [MASK_W-1:0] d_c_wmask;
  logic [DATA_W-1:0] d_c_wdata;
  logic              grant_d;
  logic              issue;
  logic              i_done;
  logic              d_done;

  assign i_req = |imem_rmask_i;
  assign d_req = (|dmem_rmask_i) | (|dmem_wmask_i);

  // Candidates in IDLE: a pending slot, or a pulse arriving this very cycle.
  // A valid slot shadows the live pulse, which is dropped in that case anyway.
  assign i_cand    = i_vld_q | i_req;
  assign d_cand    = d_vld_q | d_req;
  assign i_c_addr  = i_vld_q ? i_addr_q  : imem_addr_i;
  assign i_c_rmask = i_vld_q ? i_rmask_q : imem_rmask_i;
  assign d_c_addr  = d_vld_q ? d_addr_q  : dmem_addr_i;
  assign d_c_rmask = d_vld_q ? d_rmask_q : dmem_rmask_i;
  assign d_c_wmask = d_vld_q ? d_wmask_q : dmem_wmask_i;
  assign d_c_wdata = d_vld_q ? d_wdata_q : dmem_wdata_i;

`ifdef ARB_RR_EN
  localparam logic GNT_IMEM = 1'b0;
  localparam logic GNT_DMEM = 1'b1;
  logic last_grant_q;
  // On a tie the port not granted last wins; a lone candidate always wins.
  assign grant_d = d_cand & (~i_cand | (last_grant_q == GNT_IMEM));
`else
  assign grant_d = d_cand;
`endif

  assign issue  = (state_q == ST_IDLE) & (i_cand | d_cand);
  assign i_done = (state_q == ST_WAIT_I) & mem_resp_i;
  assign d_done = (state_q == ST_WAIT_D) & mem_resp_i;

  assign imem_resp_o  = i_done;
  assign imem_rdata_o = i_done ? mem_rdata_i : '0;
  assign dmem_resp_o  = d_done;
  assign dmem_rdata_o = d_done ? mem_rdata_i : '0;
  assign busy_o       = (state_q != ST_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      i_vld_q     <= 1'b0;
      i_addr_q    <= '0;
      i_rmask_q   <= '0;
      d_vld_q     <= 1'b0;
      d_addr_q    <= '0;
      d_rmask_q   <= '0;
      d_wmask_q   <= '0;
      d_wdata_q   <= '0;
      mem_addr_o  <= '0;
      mem_rmask_o <= '0;
      mem_wmask_o <= '0;
      mem_wdata_o <= '0;
`ifdef ARB_RR_EN
      last_grant_q <= GNT_DMEM;
`endif
    end else begin
      // Masks are single-cycle pulses; address and wdata hold until the next issue.
      mem_rmask_o <= '0;
      mem_wmask_o <= '0;

      if (i_req && !i_vld_q) begin
        i_vld_q   <= 1'b1;
        i_addr_q  <= imem_addr_i;
        i_rmask_q <= imem_rmask_i;
      end
      if (d_req && !d_vld_q) begin
        d_vld_q   <= 1'b1;
        d_addr_q  <= dmem_addr_i;
        d_rmask_q <= dmem_rmask_i;
        d_wmask_q <= dmem_wmask_i;
        d_wdata_q <= dmem_wdata_i;
      end

      case (state_q)
        ST_IDLE: begin
          if (issue) begin
            if (grant_d) begin
              mem_addr_o  <= d_c_addr;
              // A combined read+write pulse is treated as a write only.
              mem_rmask_o <= (|d_c_wmask) ? '0 : d_c_rmask;
              mem_wmask_o <= d_c_wmask;
              mem_wdata_o <= d_c_wdata;
              state_q     <= ST_WAIT_D;
            end else begin
              mem_addr_o  <= i_c_addr;
              mem_rmask_o <= i_c_rmask;
              mem_wdata_o <= '0;
              state_q     <= ST_WAIT_I;
            end
`ifdef ARB_RR_EN
            last_grant_q <= grant_d ? GNT_DMEM : GNT_IMEM;
`endif
          end
        end
        ST_WAIT_I: begin
          if (mem_resp_i) begin
            i_vld_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_WAIT_D: begin
          if (mem_resp_i) begin
            d_vld_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  // A requester pulsing into its own busy slot loses that request.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(i_req && i_vld_q)) else $warning("mem_arbiter: imem request dropped, slot busy");
      assert (!(d_req && d_vld_q)) else $warning("mem_arbiter: dmem request dropped, slot busy");
    end
  end
`endif

endmodule
